// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and lock-state type, common to the
// sync decoder and the sync generator.
package vga_timing_pkg;

    localparam int CNT_W = 12;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int LOCK_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to the
// idle level so no false edge is seen when reset releases.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming VGA syncs, measures line and
// frame lengths, and locks once the timing matches the expected mode.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hsync,
    input  logic              i_vsync,
    output logic [CNT_W-1:0]  o_x,
    output logic [CNT_W-1:0]  o_y,
    output logic              o_de,
    output logic              o_frame_start,
    output logic              o_locked,
    output logic [CNT_W-1:0]  o_h_total,
    output logic [CNT_W-1:0]  o_v_total,
    output logic              o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_TOTAL_L = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_TOTAL_L = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT_LO  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_HI  = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LO  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_HI  = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              hs_sync_p0, vs_sync_p0;
    logic              hs_sync_p1, vs_sync_p1;
    logic              hs_fall, vs_fall, frame_start;
    logic [CNT_W-1:0]  hcnt, vcnt;
    logic              vs_pend;
    logic [CNT_W-1:0]  h_len, v_len;
    logic              line_bad, frame_bad, sync_lost;
    logic              active_p1;

    lock_state_e       state, state_nxt;
    logic [7:0]        good_cnt;
    logic              good_clr, good_inc;
    logic              lose_lock;

    // stage p0: pin -> two-flop synchronizers
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_hs (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_hsync),
        .q     (hs_sync_p0)
    );

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_vs (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_vsync),
        .q     (vs_sync_p0)
    );

    // stage p1: edge-detect register; a falling edge marks sync start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_sync_p1 <= 1'b1;
            vs_sync_p1 <= 1'b1;
        end else begin
            hs_sync_p1 <= hs_sync_p0;
            vs_sync_p1 <= vs_sync_p0;
        end
    end

    assign hs_fall     = hs_sync_p1 & ~hs_sync_p0;
    assign vs_fall     = vs_sync_p1 & ~vs_sync_p0;
    assign frame_start = hs_fall & (vs_pend | vs_fall);

    assign h_len     = sat_inc(hcnt);
    assign v_len     = sat_inc(vcnt);
    assign line_bad  = hs_fall && (h_len != H_TOTAL_L);
    assign frame_bad = frame_start && (v_len != V_TOTAL_L);
    // a reloading edge takes precedence; its length already fails the line check
    assign sync_lost = (hcnt == CNT_MAX) && !hs_fall;

    // stage p2: position counters, vsync is held pending until the next line start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            vs_pend <= 1'b0;
        end else begin
            hcnt <= hs_fall ? '0 : sat_inc(hcnt);
            if (frame_start) begin
                vcnt    <= '0;
                vs_pend <= 1'b0;
            end else begin
                if (hs_fall) vcnt <= sat_inc(vcnt);
                if (vs_fall) vs_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_clr  = 1'b0;
        good_inc  = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (frame_start) begin
                    state_nxt = ST_ACQUIRE;
                    good_clr  = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (sync_lost || line_bad || frame_bad) begin
                    state_nxt = ST_SEARCH;
                end else if (frame_start) begin
                    good_inc = 1'b1;
                    if ((int'(good_cnt) + 1) >= LOCK_FRAMES) state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (sync_lost || line_bad || frame_bad) state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        o_locked  = (state == ST_LOCKED);
        lose_lock = (state == ST_LOCKED) && (state_nxt != ST_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            good_cnt <= '0;
        end else if (good_clr) begin
            good_cnt <= '0;
        end else if (good_inc) begin
            good_cnt <= sat_inc8(good_cnt);
        end
    end

    assign active_p1 = (hcnt >= H_ACT_LO) && (hcnt <= H_ACT_HI) &&
                       (vcnt >= V_ACT_LO) && (vcnt <= V_ACT_HI);

    // stage p3: registered outputs, one cycle behind the counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x           <= '0;
            o_y           <= '0;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_h_total     <= '0;
            o_v_total     <= '0;
            o_err         <= 1'b0;
        end else begin
            o_x           <= active_p1 ? hcnt - H_ACT_LO : '0;
            o_y           <= active_p1 ? vcnt - V_ACT_LO : '0;
            // gate with the next state so o_de never outlives o_locked
            o_de          <= active_p1 && (state_nxt == ST_LOCKED);
            o_frame_start <= frame_start;
            o_err         <= lose_lock;
            if (hs_fall) o_h_total <= h_len;
            // the first frame start after reset or SEARCH entry has no valid frame behind it
            if (frame_start && (state != ST_SEARCH)) o_v_total <= v_len;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced timing mode
// (40-pixel lines, 13-line frames) so every scenario runs in a few thousand cycles.
module tb_vga_sync_decoder;

    // reduced mode: H = 20 act + 4 fp + 6 sync + 10 bp = 40, V = 6 + 2 + 2 + 3 = 13
    localparam int H_ACT_T  = 20;
    localparam int H_FP_T   = 4;
    localparam int H_SYNC_T = 6;
    localparam int H_BP_T   = 10;
    localparam int H_TOT_T  = 40;
    localparam int V_ACT_T  = 6;
    localparam int V_FP_T   = 2;
    localparam int V_SYNC_T = 2;
    localparam int V_BP_T   = 3;
    localparam int V_TOT_T  = 13;
    localparam int V_OFF_T  = 5;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_hsync = 1'b1;
    logic        i_vsync = 1'b1;
    logic [11:0] o_x, o_y, o_h_total, o_v_total;
    logic        o_de, o_frame_start, o_locked, o_err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int lock_rise = 0;
    int de_bad = 0;
    logic lock_q = 1'b0;

    // prb_*[p] holds outputs after the clock edge that captured pixel p-1
    logic [11:0] prb_x [0:63];
    logic [11:0] prb_y [0:63];
    logic        prb_de [0:63];
    logic        prb_lock [0:63];
    logic        prb_err [0:63];
    logic        prb_fs [0:63];
    logic [63:0] snap_bus;
    int          e0, r0;

    vga_sync_decoder #(
        .H_ACTIVE    (H_ACT_T),
        .H_FP        (H_FP_T),
        .H_SYNC      (H_SYNC_T),
        .H_BP        (H_BP_T),
        .V_ACTIVE    (V_ACT_T),
        .V_FP        (V_FP_T),
        .V_SYNC      (V_SYNC_T),
        .V_BP        (V_BP_T),
        .LOCK_FRAMES (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_hsync       (i_hsync),
        .i_vsync       (i_vsync),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_de          (o_de),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_h_total     (o_h_total),
        .o_v_total     (o_v_total),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        lock_q <= o_locked;
        if (o_err) err_cnt <= err_cnt + 1;
        if (o_locked && !lock_q) lock_rise <= lock_rise + 1;
        if (o_de && !o_locked) de_bad <= de_bad + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_line(input int len, input logic vs_lvl, input int rst_at);
        for (int p = 0; p < len; p++) begin
            prb_x[p] = o_x; prb_y[p] = o_y; prb_de[p] = o_de;
            prb_lock[p] = o_locked; prb_err[p] = o_err; prb_fs[p] = o_frame_start;
            i_hsync = (p < H_SYNC_T) ? 1'b0 : 1'b1;
            i_vsync = vs_lvl;
            if (p == rst_at + 1) i_rst_n = 1'b1;
            if (p == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                snap_bus = {12'd0, o_x, o_y, o_de, o_frame_start, o_locked,
                            o_h_total, o_v_total, o_err};
            end
            @(negedge clk);
        end
        prb_x[len] = o_x; prb_y[len] = o_y; prb_de[len] = o_de;
        prb_lock[len] = o_locked; prb_err[len] = o_err; prb_fs[len] = o_frame_start;
    endtask

    task automatic drive_lines(input int first, input int last);
        for (int l = first; l <= last; l++)
            drive_line(H_TOT_T, (l < V_SYNC_T) ? 1'b0 : 1'b1, -1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {12'd0, o_x, o_y, o_de, o_frame_start, o_locked,
                                o_h_total, o_v_total, o_err}, 64'd0);
        i_rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // acquisition from reset
        drive_lines(0, V_TOT_T - 1);
        check("f1_locked", o_locked, 0);
        check("f1_vtotal_not_updated", o_v_total, 0);
        drive_lines(0, V_TOT_T - 1);
        check("f2_locked", o_locked, 0);
        check("f2_vtotal", o_v_total, 13);
        drive_lines(0, 0);
        check("f3_lock_before_edge", prb_lock[2], 0);
        check("f3_lock_rise", prb_lock[3], 1);
        check("f3_fs_pulse", prb_fs[3], 1);
        check("f3_fs_one_cycle", prb_fs[4], 0);
        drive_lines(1, V_TOT_T - 1);
        check("f3_htotal", o_h_total, 40);
        check("f3_vtotal", o_v_total, 13);
        check("f3_lock_rise_count", lock_rise, 1);

        // active window timing: latency 3+6+10 = 19 -> probe index 20
        drive_lines(0, 0);
        check("blank_row_de", prb_de[20], 0);
        drive_lines(1, V_OFF_T);
        check("x0_de_early", prb_de[19], 0);
        check("x0_de", prb_de[20], 1);
        check("x0_x", prb_x[20], 0);
        check("x0_y", prb_y[20], 0);
        check("xlast_de", prb_de[39], 1);
        check("xlast_x", prb_x[39], 19);
        check("xlast_de_off", prb_de[40], 0);
        drive_lines(V_OFF_T + 1, V_TOT_T - 1);

        // one short line while locked
        e0 = err_cnt;
        drive_lines(0, 2);
        drive_line(H_TOT_T - 1, 1'b1, -1);
        drive_lines(4, 4);
        check("short_err_before", prb_err[2], 0);
        check("short_lock_before", prb_lock[2], 1);
        check("short_err_pulse", prb_err[3], 1);
        check("short_lock_drop", prb_lock[3], 0);
        check("short_err_one_cycle", prb_err[4], 0);
        check("short_htotal", o_h_total, 39);
        drive_lines(5, 5);
        check("short_de_off", prb_de[20], 0);
        drive_lines(6, V_TOT_T - 1);
        check("short_err_count", err_cnt - e0, 1);
        drive_lines(0, V_TOT_T - 1);
        drive_lines(0, V_TOT_T - 1);
        check("short_relock_pending", o_locked, 0);
        drive_lines(0, V_TOT_T - 1);
        check("short_relocked", o_locked, 1);
        check("short_htotal_back", o_h_total, 40);

        // hsync stops: hcnt saturates 4095 cycles after the last edge
        e0 = err_cnt;
        i_hsync = 1'b1; i_vsync = 1'b1;
        repeat (4000) @(negedge clk);
        check("stall_still_locked", o_locked, 1);
        repeat (96) @(negedge clk);
        check("stall_unlocked", o_locked, 0);
        check("stall_err_count", err_cnt - e0, 1);
        check("stall_htotal_held", o_h_total, 40);
        drive_lines(0, 0);
        check("stall_htotal_sat", o_h_total, 4095);
        drive_lines(1, V_TOT_T - 1);

        // 14-line frames never lock
        e0 = err_cnt; r0 = lock_rise;
        for (int f = 0; f < 4; f++) drive_lines(0, V_TOT_T);
        check("long_vtotal", o_v_total, 14);
        check("long_locked", o_locked, 0);
        check("long_lock_rises", lock_rise - r0, 0);
        check("long_err_count", err_cnt - e0, 0);

        // relock, then reset in the middle of an active line
        drive_lines(0, V_TOT_T - 1);
        drive_lines(0, V_TOT_T - 1);
        check("pre_rst_vtotal", o_v_total, 13);
        check("pre_rst_locked", o_locked, 0);
        drive_lines(0, V_TOT_T - 1);
        check("pre_rst_relocked", o_locked, 1);
        e0 = err_cnt;
        drive_lines(0, V_OFF_T);
        drive_line(H_TOT_T, 1'b1, 30);
        check("rst_pre_de", prb_de[30], 1);
        check("rst_pre_locked", prb_lock[30], 1);
        check("rst_outputs_async", snap_bus, 64'd0);
        drive_lines(V_OFF_T + 2, V_TOT_T - 1);
        drive_lines(0, V_TOT_T - 1);
        check("rst_d_vtotal_not_updated", o_v_total, 0);
        drive_lines(0, V_TOT_T - 1);
        check("rst_e_locked", o_locked, 0);
        check("rst_e_vtotal", o_v_total, 13);
        drive_lines(0, V_TOT_T - 1);
        check("rst_f_relocked", o_locked, 1);
        check("rst_f_htotal", o_h_total, 40);
        check("rst_err_count", err_cnt - e0, 0);
        check("de_only_when_locked", de_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
